// File: rtl/turn_scheduler.sv
// Round-robin turn sequencer for the chicken-race game: owns the active player,
// requests card flips, advances chickens on a match and detects the winner.
module turn_scheduler #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned PLAYER_W    = 2,
  parameter int unsigned TRACK_LEN   = 24,
  parameter int unsigned POS_W       = 5,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic [NUM_PLAYERS-1:0] key,
  input  logic                   flip_ack,
  input  logic                   flip_match,
  output logic                   flip_req,
  output logic [PLAYER_W-1:0]    turn_player,
  output logic [POS_W-1:0]       cur_pos,
  output logic                   move_pulse,
  output logic                   win,
  output logic [PLAYER_W-1:0]    winner,
  output logic                   busy
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [POS_W-1:0]    POS_LAST    = POS_W'(TRACK_LEN - 1);
  localparam logic [PLAYER_W-1:0] PLAYER_LAST = PLAYER_W'(NUM_PLAYERS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_KEY,
    FLIP,
    WAIT_ACK,
    ADVANCE,
    NEXT,
    DONE
  } state_t;

  state_t              state;
  logic [TIMER_W-1:0]  timer;
  logic [POS_W-1:0]    pos [NUM_PLAYERS];
  logic [POS_W-1:0]    pos_cur;
  logic [PLAYER_W-1:0] next_player;

  assign pos_cur     = pos[turn_player];
  assign next_player = (turn_player == PLAYER_LAST) ? '0 : turn_player + 1'b1;

  // cur_pos is loaded alongside every change of pos or turn_player so it stays a pure register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      timer       <= '0;
      turn_player <= '0;
      cur_pos     <= '0;
      flip_req    <= 1'b0;
      move_pulse  <= 1'b0;
      win         <= 1'b0;
      winner      <= '0;
      busy        <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) pos[i] <= '0;
    end else begin
      flip_req   <= 1'b0;
      move_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_PLAYERS; i++) pos[i] <= '0;
            turn_player <= '0;
            cur_pos     <= '0;
            timer       <= '0;
            busy        <= 1'b1;
            state       <= WAIT_KEY;
          end
        end
        WAIT_KEY: begin
          // a key press on the final timeout cycle still takes the turn
          if (key[turn_player]) begin
            flip_req <= 1'b1;
            state    <= FLIP;
          end else if (timer == TIMER_LAST) begin
            state <= NEXT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FLIP: state <= WAIT_ACK;
        WAIT_ACK: begin
          if (flip_ack) begin
            if (flip_match) begin
              move_pulse <= 1'b1;
              state      <= ADVANCE;
            end else begin
              state <= NEXT;
            end
          end
        end
        ADVANCE: begin
          if (pos_cur == POS_LAST) begin
            winner <= turn_player;
            win    <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            pos[turn_player] <= pos_cur + 1'b1;
            cur_pos          <= pos_cur + 1'b1;
            timer            <= '0;
            state            <= WAIT_KEY;
          end
        end
        NEXT: begin
          turn_player <= next_player;
          cur_pos     <= pos[next_player];
          timer       <= '0;
          state       <= WAIT_KEY;
        end
        DONE: begin
          if (!start) begin
            win   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed vector bench for turn_scheduler with a short track and short timeout.
module tb_turn_scheduler;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic [3:0] key;
  logic       flip_ack;
  logic       flip_match;
  logic       flip_req;
  logic [1:0] turn_player;
  logic [4:0] cur_pos;
  logic       move_pulse;
  logic       win;
  logic [1:0] winner;
  logic       busy;

  int ntests = 0;
  int nfail  = 0;

  turn_scheduler #(
    .NUM_PLAYERS(4),
    .PLAYER_W(2),
    .TRACK_LEN(3),
    .POS_W(5),
    .TIMEOUT_CYC(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .start(start),
    .key(key),
    .flip_ack(flip_ack),
    .flip_match(flip_match),
    .flip_req(flip_req),
    .turn_player(turn_player),
    .cur_pos(cur_pos),
    .move_pulse(move_pulse),
    .win(win),
    .winner(winner),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       st;
    logic [3:0] key;
    logic       ack;
    logic       mt;
    logic       fr;
    logic       mp;
    logic [1:0] tp;
    logic [4:0] cp;
    logic       w;
    logic [1:0] wn;
    logic       b;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic [3:0] k, input logic ack,
                              input logic mt, input logic fr, input logic mp,
                              input logic [1:0] tp, input logic [4:0] cp,
                              input logic w, input logic [1:0] wn, input logic b);
    vec_t r;
    r.st = st; r.key = k; r.ack = ack; r.mt = mt;
    r.fr = fr; r.mp = mp; r.tp = tp; r.cp = cp; r.w = w; r.wn = wn; r.b = b;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " flip_req"}, int'(flip_req), 0);
    chk({tag, " move_pulse"}, int'(move_pulse), 0);
    chk({tag, " turn_player"}, int'(turn_player), 0);
    chk({tag, " cur_pos"}, int'(cur_pos), 0);
    chk({tag, " win"}, int'(win), 0);
    chk({tag, " winner"}, int'(winner), 0);
    chk({tag, " busy"}, int'(busy), 0);
  endtask

  initial begin
    // Game script: hit, miss, foreign keys + timeout, key on last timeout cycle, win, restart
    //                st key     ack mt  | fr mp tp cp w wn b
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // 0 IDLE -> WAIT_KEY
    vecs.push_back(mk(1, 4'b0001, 0, 0, 1, 0, 0, 0, 0, 0, 1)); // 1 key -> FLIP
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // 2 -> WAIT_ACK
    vecs.push_back(mk(1, 4'b0000, 1, 1, 0, 1, 0, 0, 0, 0, 1)); // 3 hit -> ADVANCE
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 1)); // 4 pos 1, same player
    vecs.push_back(mk(1, 4'b0001, 0, 0, 1, 0, 0, 1, 0, 0, 1)); // 5 FLIP
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 1)); // 6 WAIT_ACK
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 1)); // 7 hold, no timeout
    vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 0, 1, 0, 0, 1)); // 8 miss -> NEXT
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 1)); // 9 player 1
    vecs.push_back(mk(1, 4'b1101, 0, 0, 0, 0, 1, 0, 0, 0, 1)); // 10 foreign keys, timer 1
    vecs.push_back(mk(1, 4'b1101, 0, 0, 0, 0, 1, 0, 0, 0, 1)); // 11 timer 2
    vecs.push_back(mk(1, 4'b1101, 0, 0, 0, 0, 1, 0, 0, 0, 1)); // 12 timer 3
    vecs.push_back(mk(1, 4'b1101, 0, 0, 0, 0, 1, 0, 0, 0, 1)); // 13 4th cycle -> NEXT
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 2, 0, 0, 0, 1)); // 14 player 2
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 2, 0, 0, 0, 1)); // 15
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 2, 0, 0, 0, 1)); // 16
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 2, 0, 0, 0, 1)); // 17
    vecs.push_back(mk(1, 4'b0100, 0, 0, 1, 0, 2, 0, 0, 0, 1)); // 18 key beats timeout
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 2, 0, 0, 0, 1)); // 19
    vecs.push_back(mk(1, 4'b0000, 1, 1, 0, 1, 2, 0, 0, 0, 1)); // 20 hit 1
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 2, 1, 0, 0, 1)); // 21 pos 1
    vecs.push_back(mk(1, 4'b0100, 0, 0, 1, 0, 2, 1, 0, 0, 1)); // 22
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 2, 1, 0, 0, 1)); // 23
    vecs.push_back(mk(1, 4'b0000, 1, 1, 0, 1, 2, 1, 0, 0, 1)); // 24 hit 2
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 2, 2, 0, 0, 1)); // 25 pos 2
    vecs.push_back(mk(1, 4'b0100, 0, 0, 1, 0, 2, 2, 0, 0, 1)); // 26
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 2, 2, 0, 0, 1)); // 27
    vecs.push_back(mk(1, 4'b0000, 1, 1, 0, 1, 2, 2, 0, 0, 1)); // 28 hit 3
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 2, 2, 1, 2, 0)); // 29 DONE, no wrap
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 2, 2, 1, 2, 0)); // 30 start held
    vecs.push_back(mk(1, 4'b0100, 1, 1, 0, 0, 2, 2, 1, 2, 0)); // 31 inputs ignored
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 2, 2, 0, 0, 0)); // 32 -> IDLE
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 2, 2, 0, 0, 0)); // 33 IDLE
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // 34 new game

    RST = 1'b1; start = 1'b0; key = '0; flip_ack = 1'b0; flip_match = 1'b0;
    step();
    step();
    chk_reset_outputs("reset");
    RST = 1'b0;

    foreach (vecs[i]) begin
      start = vecs[i].st; key = vecs[i].key; flip_ack = vecs[i].ack; flip_match = vecs[i].mt;
      step();
      chk($sformatf("v%0d flip_req", i), int'(flip_req), int'(vecs[i].fr));
      chk($sformatf("v%0d move_pulse", i), int'(move_pulse), int'(vecs[i].mp));
      chk($sformatf("v%0d turn_player", i), int'(turn_player), int'(vecs[i].tp));
      chk($sformatf("v%0d cur_pos", i), int'(cur_pos), int'(vecs[i].cp));
      chk($sformatf("v%0d win", i), int'(win), int'(vecs[i].w));
      chk($sformatf("v%0d busy", i), int'(busy), int'(vecs[i].b));
      if (vecs[i].w) chk($sformatf("v%0d winner", i), int'(winner), int'(vecs[i].wn));
    end

    // Three timeouts bring the turn to player 3, then a miss wraps to player 0
    key = '0; flip_ack = 1'b0; flip_match = 1'b0;
    for (int c = 0; c < 15; c++) step();
    chk("wrap tp before", int'(turn_player), 3);
    key = 4'b1000;
    step();
    chk("wrap flip_req", int'(flip_req), 1);
    key = '0;
    step();
    flip_ack = 1'b1; flip_match = 1'b0;
    step();
    chk("wrap tp at ack+1", int'(turn_player), 3);
    flip_ack = 1'b0;
    step();
    chk("wrap tp at ack+2", int'(turn_player), 0);
    chk("wrap move_pulse", int'(move_pulse), 0);

    // Reset while waiting for the ack; a late ack must be ignored
    key = 4'b0001;
    step();
    chk("rst flip_req", int'(flip_req), 1);
    key = '0;
    step();
    chk("rst busy before", int'(busy), 1);
    #2 RST = 1'b1;
    #1 chk_reset_outputs("async reset");
    step();
    RST = 1'b0; start = 1'b0; flip_ack = 1'b1; flip_match = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("late ack move_pulse c%0d", c), int'(move_pulse), 0);
      chk($sformatf("late ack busy c%0d", c), int'(busy), 0);
      chk($sformatf("late ack cur_pos c%0d", c), int'(cur_pos), 0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
